// File: rtl/ifns_pkg.sv
// rtl/ifns_pkg.sv - shared widths, lane ID type and IFNS weight helper
package ifns_pkg;

  localparam int IFNS_CODE_W    = 27;
  localparam int IFNS_DATA_W    = 19;
  localparam int GRANT_CNT_W    = 16;
  localparam int LANE_ID_MAX_W  = 3;

  typedef logic [LANE_ID_MAX_W-1:0] lane_id_t;

  // Weight of codeword bit k (k=0 is d1): Fibonacci series 1, 2, 3, 5, 8, ...
  function automatic logic [IFNS_DATA_W-1:0] ifns_weight(input int k);
    logic [IFNS_DATA_W:0] a;
    logic [IFNS_DATA_W:0] b;
    logic [IFNS_DATA_W:0] t;
    a = 1;
    b = 2;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a[IFNS_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/decoderIFNS_19di_core.sv
// rtl/decoderIFNS_19di_core.sv - combinational 27-bit IFNS codeword to 19-bit data decoder
module decoderIFNS_19di_core
  import ifns_pkg::*;
(
  input  logic [IFNS_CODE_W-1:0] code,
  output logic [IFNS_DATA_W-1:0] data
);

  // Weighted Fibonacci sum; invalid codewords simply wrap modulo 2^19.
  always_comb begin
    data = '0;
    for (int i = 0; i < IFNS_CODE_W; i++) begin
      if (code[i]) data = data + ifns_weight(i);
    end
  end

endmodule

// File: rtl/ifns_decode_arbiter_rr_grant.sv
// rtl/ifns_decode_arbiter_rr_grant.sv - round-robin one-hot grant from a rotating pointer
module rr_grant #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [LW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!any_grant && eligible[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/ifns_decode_arbiter.sv
// rtl/ifns_decode_arbiter.sv - round-robin lane arbiter sharing one IFNS decoder core
module ifns_decode_arbiter
  import ifns_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CODE_W    = IFNS_CODE_W,
  parameter int DATA_W    = IFNS_DATA_W,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM_LANES-1:0]          cfg_lane_en,
  input  logic [NUM_LANES-1:0]          req_valid,
  input  logic [NUM_LANES*CODE_W-1:0]   req_code,
  output logic [NUM_LANES-1:0]          req_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [LANE_W-1:0]             out_lane,
  input  logic                          out_ready,
  output logic [GRANT_CNT_W-1:0]        grant_cnt
);

  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_data_q,  out_data_d;
  logic [LANE_W-1:0]      out_lane_q,  out_lane_d;
  logic [LANE_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [GRANT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  logic                   accept;
  logic [NUM_LANES-1:0]   eligible;
  logic [NUM_LANES-1:0]   grant;
  logic [LANE_W-1:0]      grant_idx;
  logic                   any_grant;
  logic [CODE_W-1:0]      code_mux;
  logic [DATA_W-1:0]      code_dec;

  assign accept   = ~out_valid_q | out_ready;
  assign eligible = req_valid & cfg_lane_en;

  rr_grant #(
    .N  (NUM_LANES),
    .LW (LANE_W)
  ) u_rr_grant (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = accept ? grant : '0;
  assign code_mux  = req_code[int'(grant_idx)*CODE_W +: CODE_W];

  decoderIFNS_19di_core u_core (
    .code (code_mux),
    .data (code_dec)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    if (accept) begin
      out_valid_d = any_grant;
      if (any_grant) begin
        out_data_d = code_dec;
        out_lane_d = grant_idx;
        rr_ptr_d   = (grant_idx == LANE_W'(NUM_LANES-1)) ? '0 : grant_idx + 1'b1;
        if (grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_ifns_decode_arbiter.sv
// tb/tb_ifns_decode_arbiter.sv - directed self-checking bench for ifns_decode_arbiter
module tb_ifns_decode_arbiter;

  logic         clock;
  logic         rst_n;
  logic [3:0]   cfg_lane_en;
  logic [3:0]   req_valid;
  logic [107:0] req_code;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [18:0]  out_data;
  logic [1:0]   out_lane;
  logic         out_ready;
  logic [15:0]  grant_cnt;

  int total;
  int bad;

  logic [26:0] codes [4];
  logic [18:0] hand  [4];

  ifns_decode_arbiter dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .cfg_lane_en (cfg_lane_en),
    .req_valid   (req_valid),
    .req_code    (req_code),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_lane    (out_lane),
    .out_ready   (out_ready),
    .grant_cnt   (grant_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [18:0] golden(input logic [26:0] c);
    int a, b, t, s;
    a = 1; b = 2; s = 0;
    for (int i = 0; i < 27; i++) begin
      if (c[i]) s = s + a;
      t = a + b; a = b; b = t;
    end
    return 19'(s % 524288);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    req_valid = 4'b0000;
    cfg_lane_en = 4'b1111;
    out_ready = 1'b1;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    cfg_lane_en = 4'b1111;
    out_ready = 1'b1;
    req_code = '0;
    #12;
    total++;
    if ({out_valid, out_data, out_lane, grant_cnt, req_ready} !== 42'd0) begin
      bad++;
      $display("FAIL reset_state got v=%0b d=%0h l=%0d cnt=%0d rdy=%b exp all zero",
               out_valid, out_data, out_lane, grant_cnt, req_ready);
    end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_first_grant();
    do_reset();
    @(posedge clock); #1;
    req_code = '0;
    req_valid = 4'b0001;
    @(negedge clock);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL first_ready got=%b exp=0001", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 4'b0000;
    total++;
    if (out_valid !== 1'b1 || out_data !== 19'h0 || out_lane !== 2'd0 || grant_cnt !== 16'd1) begin
      bad++;
      $display("FAIL first_out got v=%0b d=%0h l=%0d cnt=%0d exp v=1 d=0 l=0 cnt=1",
               out_valid, out_data, out_lane, grant_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(posedge clock); #1;
    req_code = {codes[3], codes[2], codes[1], codes[0]};
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      total++;
      if (req_ready !== (4'b0001 << (c % 4))) begin
        bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, 4'b0001 << (c % 4));
      end
      @(posedge clock); #1;
      total++;
      if (out_valid !== 1'b1 || out_lane !== 2'(c % 4) || out_data !== golden(codes[c % 4])
          || out_data !== hand[c % 4]) begin
        bad++;
        $display("FAIL rr_out[%0d] got v=%0b l=%0d d=%0h exp v=1 l=%0d d=%0h",
                 c, out_valid, out_lane, out_data, c % 4, hand[c % 4]);
      end
    end
    req_valid = 4'b0000;
    total++;
    if (grant_cnt !== 16'd8) begin
      bad++; $display("FAIL rr_count got=%0d exp=8", grant_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    @(posedge clock); #1;
    req_code = {codes[3], codes[2], codes[1], codes[0]};
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      total++;
      if (req_ready !== 4'b0000) begin
        bad++; $display("FAIL stall_ready[%0d] got=%b exp=0000", c, req_ready);
      end
      @(posedge clock); #1;
      total++;
      if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 19'd1) begin
        bad++;
        $display("FAIL stall_hold[%0d] got v=%0b l=%0d d=%0h exp v=1 l=0 d=1",
                 c, out_valid, out_lane, out_data);
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL stall_release got=%b exp=0010", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 4'b0000;
    total++;
    if (out_lane !== 2'd1 || out_data !== 19'd2) begin
      bad++; $display("FAIL stall_next got l=%0d d=%0h exp l=1 d=2", out_lane, out_data);
    end
  endtask

  task automatic test_lane_mask();
    do_reset();
    @(posedge clock); #1;
    req_code = {codes[3], codes[2], codes[1], codes[0]};
    cfg_lane_en = 4'b1010;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      total++;
      if (req_ready !== ((c % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        bad++; $display("FAIL mask_ready[%0d] got=%b exp=%b", c, req_ready,
                        (c % 2 == 0) ? 4'b0010 : 4'b1000);
      end
      @(posedge clock); #1;
      total++;
      if (out_lane !== ((c % 2 == 0) ? 2'd1 : 2'd3)) begin
        bad++; $display("FAIL mask_lane[%0d] got=%0d exp=%0d", c, out_lane,
                        (c % 2 == 0) ? 1 : 3);
      end
    end
    req_valid = 4'b0000;
    cfg_lane_en = 4'b1111;
  endtask

  task automatic test_drain_hold();
    do_reset();
    @(posedge clock); #1;
    req_code = {codes[3], 27'h7FFFFFF, codes[1], codes[0]};
    req_valid = 4'b0100;
    @(negedge clock);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL drain_ready got=%b exp=0100", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 4'b0000;
    total++;
    if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== 19'h4B226) begin
      bad++;
      $display("FAIL drain_word got v=%0b l=%0d d=%0h exp v=1 l=2 d=4b226", out_valid, out_lane, out_data);
    end
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b0 || out_lane !== 2'd2 || out_data !== 19'h4B226) begin
      bad++;
      $display("FAIL drain_empty got v=%0b l=%0d d=%0h exp v=0 l=2 d=4b226", out_valid, out_lane, out_data);
    end
    req_valid = 4'b1111;
    @(negedge clock);
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL drain_ptr got=%b exp=1000", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(posedge clock); #1;
    req_code = {codes[3], codes[2], codes[1], codes[0]};
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 19'd1 || grant_cnt !== 16'd1) begin
      bad++;
      $display("FAIL areset_pre got v=%0b d=%0h cnt=%0d exp v=1 d=1 cnt=1", out_valid, out_data, grant_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 19'd0 || grant_cnt !== 16'd0) begin
      bad++;
      $display("FAIL areset_now got v=%0b d=%0h cnt=%0d exp v=0 d=0 cnt=0", out_valid, out_data, grant_cnt);
    end
    @(negedge clock);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL areset_first got=%b exp=0001", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 4'b0000;
    total++;
    if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 19'd1) begin
      bad++;
      $display("FAIL areset_out got v=%0b l=%0d d=%0h exp v=1 l=0 d=1", out_valid, out_lane, out_data);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    codes[0] = 27'h0000001; hand[0] = 19'd1;
    codes[1] = 27'h0000002; hand[1] = 19'd2;
    codes[2] = 27'h0000005; hand[2] = 19'd4;
    codes[3] = 27'h4000000; hand[3] = 19'h4D973;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_stall();
    test_lane_mask();
    test_drain_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
